// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: captures one 128-bit state, pushes one column
// per clock through a single shared column multiplier, then holds the
// result until the downstream side accepts it.
module mix_columns_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_reg;
  state_t       state_next;
  logic [1:0]   col_reg;
  logic [127:0] buf_reg;
  logic [31:0]  col_word [4];
  logic [31:0]  result_col [4];
  logic [31:0]  col_in;
  logic [31:0]  col_out;
  logic         accept;

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Handshakes only depend on the registered state, never on the inputs.
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign accept    = in_valid && in_ready;

  // Column c of the buffer lives at bits [127-32c -: 32]; row 0 is the MSB.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cols
      assign col_word[gi] = buf_reg[127-32*gi -: 32];
    end
  endgenerate

  assign col_in = col_word[col_reg];

  // The one shared column multiplier.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] d0, d1, d2, d3;
    a0 = col_in[31:24];
    a1 = col_in[23:16];
    a2 = col_in[15:8];
    a3 = col_in[7:0];
    d0 = xtime(a0);
    d1 = xtime(a1);
    d2 = xtime(a2);
    d3 = xtime(a3);
    col_out = {d0 ^ d1 ^ a1 ^ a2 ^ a3,
               a0 ^ d1 ^ d2 ^ a2 ^ a3,
               a0 ^ a1 ^ d2 ^ d3 ^ a3,
               d0 ^ a0 ^ a1 ^ a2 ^ d3};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode: four RUN cycles, then hold in DONE until accepted.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (col_reg == 2'd3) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Input buffer: sampled once at the handshake, so later in_state changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_reg <= 128'h0;
    end else if (accept) begin
      buf_reg <= in_state;
    end
  end

  // Column counter: cleared on capture, steps once per RUN cycle and wraps to 0 entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg <= 2'd0;
    end else if (accept) begin
      col_reg <= 2'd0;
    end else if (state_reg == RUN) begin
      col_reg <= col_reg + 2'd1;
    end
  end

  // Result register, one 32-bit slice per column, written when the counter selects it.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_result
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          result_col[gi] <= 32'h0;
        end else if (state_reg == RUN && col_reg == 2'(gi)) begin
          result_col[gi] <= col_out;
        end
      end
    end
  endgenerate

  assign out_state = {result_col[0], result_col[1], result_col[2], result_col[3]};

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed self-checking bench for mix_columns_seq.
module tb_mix_columns_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mix_columns_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: carry-less product then polynomial reduction by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = 15'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  // Circulant matrix with first row {2,3,1,1}.
  function automatic logic [31:0] model_col(input logic [31:0] w);
    logic [7:0] a [4];
    logic [7:0] coef [4];
    logic [31:0] r;
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    for (int j = 0; j < 4; j++) a[j] = w[31-8*j -: 8];
    r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] acc;
      acc = 8'h0;
      for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[j], coef[(j - i + 4) % 4]);
      r[31-8*i -: 8] = acc;
    end
    return r;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = model_col(s[127-32*c -: 32]);
    return r;
  endfunction

  task automatic start_op(input logic [127:0] st);
    @(negedge clk);
    check("in_ready_idle", {127'h0, in_ready}, 128'h1);
    in_valid = 1'b1;
    in_state = st;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("busy_after_accept", {127'h0, busy}, 128'h1);
  endtask

  task automatic expect_result(input string tag, input logic [127:0] exp);
    repeat (3) begin
      @(posedge clk);
      #1;
      check({tag, "_early_valid"}, {127'h0, out_valid}, 128'h0);
    end
    @(posedge clk);
    #1;
    check({tag, "_valid"}, {127'h0, out_valid}, 128'h1);
    check({tag, "_data"}, out_state, exp);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("released_valid", {127'h0, out_valid}, 128'h0);
    check("released_ready", {127'h0, in_ready}, 128'h1);
    check("released_busy", {127'h0, busy}, 128'h0);
  endtask

  task automatic reset_check(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_valid"}, {127'h0, out_valid}, 128'h0);
    check({tag, "_busy"}, {127'h0, busy}, 128'h0);
    check({tag, "_data"}, out_state, 128'h0);
    check({tag, "_ready"}, {127'h0, in_ready}, 128'h1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [127:0] vec_in  [6];
  logic [127:0] vec_out [6];
  logic [127:0] stream_in [8];
  int hs;
  int last_out;
  bit found;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_state = 128'h0;

    // Reset state; in_valid while in reset must not capture.
    repeat (2) @(posedge clk);
    in_valid = 1'b1;
    in_state = 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff;
    @(posedge clk);
    #1;
    check("rst_busy", {127'h0, busy}, 128'h0);
    check("rst_valid", {127'h0, out_valid}, 128'h0);
    check("rst_data", out_state, 128'h0);
    check("rst_ready", {127'h0, in_ready}, 128'h1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 round-1 vector with exact 4-clock latency.
    start_op(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5);
    expect_result("fips", 128'h046681e5_e0cb199a_48f8d37a_2806264c);
    $display("fips: out=%h", out_state);
    release_out();

    // Column vectors replicated in every column, plus one mixed state.
    vec_in[0] = {4{32'hdb135345}}; vec_out[0] = {4{32'h8e4da1bc}};
    vec_in[1] = {4{32'hf20a225c}}; vec_out[1] = {4{32'h9fdc589d}};
    vec_in[2] = {4{32'hd4d4d4d5}}; vec_out[2] = {4{32'hd5d5d7d6}};
    vec_in[3] = {4{32'h01010101}}; vec_out[3] = {4{32'h01010101}};
    vec_in[4] = {4{32'hc6c6c6c6}}; vec_out[4] = {4{32'hc6c6c6c6}};
    vec_in[5] = 128'hdb135345_f20a225c_d4d4d4d5_c6c6c6c6;
    vec_out[5] = 128'h8e4da1bc_9fdc589d_d5d5d7d6_c6c6c6c6;
    for (int v = 0; v < 6; v++) begin
      start_op(vec_in[v]);
      expect_result($sformatf("vec%0d", v), vec_out[v]);
      $display("vec%0d: in=%h out=%h", v, vec_in[v], out_state);
      release_out();
    end

    // Backpressure: hold 10 clocks in DONE while a new in_valid is offered.
    start_op(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5);
    expect_result("bp", 128'h046681e5_e0cb199a_48f8d37a_2806264c);
    in_valid = 1'b1;
    in_state = {4{32'h2d26314c}};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", {127'h0, out_valid}, 128'h1);
      check("bp_hold_data", out_state, 128'h046681e5_e0cb199a_48f8d37a_2806264c);
      check("bp_hold_ready", {127'h0, in_ready}, 128'h0);
    end
    in_valid = 1'b0;
    $display("backpressure: held 10 clocks out=%h", out_state);
    release_out();

    // in_state changes every RUN cycle; only the captured value matters.
    start_op(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5);
    for (int i = 0; i < 4; i++) begin
      in_state = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
    end
    check("midchg_valid", {127'h0, out_valid}, 128'h1);
    check("midchg_data", out_state, 128'h046681e5_e0cb199a_48f8d37a_2806264c);
    $display("mid-change: out=%h", out_state);
    release_out();

    // Reset after column 1 has been written.
    start_op({4{32'hdb135345}});
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset_check("rst_run");
    start_op({4{32'h2d26314c}});
    expect_result("after_rst_run", {4{32'h4d7ebdf8}});
    $display("reset mid-RUN then op: out=%h", out_state);

    // Reset while a result is presented in DONE.
    reset_check("rst_done");
    start_op({4{32'h2d26314c}});
    expect_result("after_rst_done", {4{32'h4d7ebdf8}});
    $display("reset mid-DONE then op: out=%h", out_state);
    release_out();

    // Streaming: in_valid and out_ready held high, 6-clock spacing.
    for (int n = 0; n < 8; n++) stream_in[n] = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1;
    @(negedge clk);
    check("stream_ready", {127'h0, in_ready}, 128'h1);
    in_valid = 1'b1;
    in_state = stream_in[0];
    @(posedge clk);
    #1;
    hs = cyc;
    last_out = 0;
    for (int n = 0; n < 8; n++) begin
      found = 1'b0;
      for (int w = 0; w < 10 && !found; w++) begin
        @(posedge clk);
        #1;
        if (out_valid) found = 1'b1;
      end
      check("stream_found", {127'h0, found}, 128'h1);
      check("stream_latency", 128'(cyc - hs), 128'd4);
      check("stream_data", out_state, model(stream_in[n]));
      if (n > 0) check("stream_spacing", 128'(cyc - last_out), 128'd6);
      $display("stream%0d: in=%h out=%h", n, stream_in[n], out_state);
      last_out = cyc;
      if (n < 7) in_state = stream_in[n + 1];
      else in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("stream_drop_valid", {127'h0, out_valid}, 128'h0);
      if (n < 7) begin
        @(posedge clk);
        #1;
        hs = cyc;
        check("stream_accept", {127'h0, busy}, 128'h1);
      end
    end
    // No stray extra result.
    repeat (8) begin
      @(posedge clk);
      #1;
      check("stream_no_extra", {127'h0, out_valid}, 128'h0);
    end
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mix_columns_seq.md
MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  in_state is valid this cycle.
REQ-005 in_ready  output  1  block can accept a state this cycle.
REQ-006 in_state  input  128  AES state to transform.
  - Column c occupies bits [127-32c -: 32], c=0..3.
  - Row 0 is the most significant byte of each column.
REQ-007 out_valid  output  1  out_state holds a completed result.
REQ-008 out_ready  input  1  downstream accepts out_state this cycle.
REQ-009 out_state  output  128  MixColumns result, same byte layout as in_state.
REQ-010 busy  output  1  high in RUN and DONE.

Function
REQ-011 Function: forward AES MixColumns over GF(2^8), reduction polynomial 0x11B; the block is the encrypt-direction counterpart of the inverse transform.
REQ-012 Per column (a0..a3 → r0..r3):
  - r0=2a0^3a1^a2^a3
  - r1=a0^2a1^3a2^a3
  - r2=a0^a1^2a2^3a3
  - r3=3a0^a1^a2^2a3
  - 2x = xtime (left shift, XOR 0x1B if bit 7 was set); 3x = xtime(x)^x.
REQ-013 Datapath: exactly one shared column multiplier; one column processed per clock.
REQ-014 FSM states: IDLE, RUN, DONE.
REQ-015 in_ready = 1 only in IDLE; out_valid = 1 only in DONE; both are registered or pure FSM decodes, with no combinational path from in_valid or out_ready.
REQ-016 IDLE: on in_valid&&in_ready:
  - capture in_state into an internal buffer;
  - clear the 2-bit column counter to 0;
  - go to RUN.
  - in_valid without in_ready is ignored.
REQ-017 RUN: each edge writes the result for column[counter] into the result register and increments the counter; after the edge that writes column 3 (counter 3), go to DONE.
REQ-018 Latency: a handshake at edge k gives out_valid=1 after edge k+4, i.e. exactly 4 clocks.
REQ-019 DONE: out_state and out_valid are held stable until out_valid&&out_ready; on that edge go to IDLE, and out_valid falls after the same edge.
REQ-020 The earliest next acceptance is the edge after the return to IDLE; back-to-back throughput is one state per 6 clocks when out_ready is held high.
REQ-021 Changes on in_state after capture have no effect on the result.
REQ-022 out_ready asserted outside DONE is ignored.
REQ-023 Counter wrap from 3 to 0 coincides with the RUN→DONE transition and is never used as an index in DONE.
REQ-024 Unused result bytes in RUN are not observable, because out_valid is 0.

Reset
REQ-025 rst_n=0 immediately forces, asynchronously:
  - FSM = IDLE, counter = 0;
  - in_ready = 1 while rst_n=0 is permitted, but no capture occurs;
  - out_valid = 0, busy = 0, out_state = 128'h0;
  - input buffer = 0.
REQ-026 Reset asserted in RUN or DONE aborts the operation; no partial result is ever presented.
REQ-027 After release, the first accept is possible on the first rising edge with in_valid=1.

Verification
REQ-028 FIPS-197 round-1 vector: in_state=d4bf5d30_e0b452ae_b84111f1_1e2798e5 -> out_state=046681e5_e0cb199a_48f8d37a_2806264c, out_valid exactly 4 clocks after the handshake.
REQ-029 Column vectors placed in all four columns, one per run:
  - db135345 -> 8e4da1bc
  - f20a225c -> 9fdc589d
  - d4d4d4d5 -> d5d5d7d6
  - 01010101 and c6c6c6c6 map to themselves.
REQ-030 Backpressure: hold out_ready=0 for 10 clocks in DONE.
  - out_state and out_valid stay stable; in_ready stays 0; a new in_valid is ignored.
  - Assert out_ready for 1 clock -> IDLE next cycle.
REQ-031 Mid-operation input change: alter in_state every RUN cycle -> result equals the transform of the captured value only.
REQ-032 Reset mid-RUN (after column 1) and mid-DONE:
  - outputs zero immediately;
  - next operation with 2d26314c in every column -> 4d7ebdf8 in every column.
REQ-033 Streaming: 8 back-to-back random states with out_ready=1 -> results match a reference model, spaced 6 clocks apart, none dropped or duplicated.
